// File: rtl/traffic_light_fsm.sv
// Traffic-light controller: main/side street phases, pedestrian walk phase,
// one-shot side-green extension and runtime-reprogrammable intervals.
module traffic_light_fsm #(
    parameter logic [3:0] DEF_BASE = 4'd6,
    parameter logic [3:0] DEF_EXT  = 4'd3,
    parameter logic [3:0] DEF_YEL  = 4'd2
) (
    input  logic       clk,
    input  logic       Reset,
    input  logic       tick,
    input  logic       Sensor_Sync,
    input  logic       Walk_request_Sync,
    input  logic       Reprogram_Sync,
    input  logic [1:0] prog_sel,
    input  logic [3:0] prog_val,
    output logic [2:0] main_lamp,
    output logic [2:0] side_lamp,
    output logic       walk_lamp,
    output logic [2:0] state_out
);

    typedef enum logic [2:0] {
        S_MG1  = 3'd0,
        S_MG2  = 3'd1,
        S_MY   = 3'd2,
        S_WALK = 3'd3,
        S_SG   = 3'd4,
        S_SY   = 3'd5
    } state_t;

    localparam logic [2:0] L_RED = 3'b100;
    localparam logic [2:0] L_YEL = 3'b010;
    localparam logic [2:0] L_GRN = 3'b001;

    state_t     state_q, state_d;
    logic [3:0] cnt_q, cnt_d;
    logic [3:0] base_q, base_d;
    logic [3:0] ext_q, ext_d;
    logic [3:0] yel_q, yel_d;
    logic       walk_pend_q, walk_pend_d;
    logic       ext_used_q, ext_used_d;
    logic [6:0] lamps_q, lamps_d;

    // Lamp pattern {main, side, walk}; unused codes show the safe MG1 pattern.
    function automatic logic [6:0] lamp_decode(input state_t s);
        case (s)
            S_MG1, S_MG2: lamp_decode = {L_GRN, L_RED, 1'b0};
            S_MY:         lamp_decode = {L_YEL, L_RED, 1'b0};
            S_WALK:       lamp_decode = {L_RED, L_RED, 1'b1};
            S_SG:         lamp_decode = {L_RED, L_GRN, 1'b0};
            S_SY:         lamp_decode = {L_RED, L_YEL, 1'b0};
            default:      lamp_decode = {L_GRN, L_RED, 1'b0};
        endcase
    endfunction

    always_comb begin
        // NOTE: every _d gets a default first so no path leaves it unassigned (no latches).
        state_d     = state_q;
        cnt_d       = cnt_q;
        base_d      = base_q;
        ext_d       = ext_q;
        yel_d       = yel_q;
        walk_pend_d = walk_pend_q;
        ext_used_d  = ext_used_q;

        if (Reprogram_Sync) begin
            if (prog_val != 4'd0) begin
                case (prog_sel)
                    2'b00:   base_d = prog_val;
                    2'b01:   ext_d  = prog_val;
                    2'b10:   yel_d  = prog_val;
                    default: ;
                endcase
            end
            state_d     = S_MG1;
            cnt_d       = base_d;
            walk_pend_d = 1'b0;
            ext_used_d  = 1'b0;
        end else if (!(state_q inside {S_MG1, S_MG2, S_MY, S_WALK, S_SG, S_SY})) begin
            state_d = S_MG1;
            cnt_d   = base_q;
        end else if (tick) begin
            if (cnt_q == 4'd1) begin
                case (state_q)
                    S_MG1: begin
                        state_d = S_MG2;
                        cnt_d   = Sensor_Sync ? ext_q : base_q;
                    end
                    S_MG2: begin
                        state_d = S_MY;
                        cnt_d   = yel_q;
                    end
                    S_MY: begin
                        if (walk_pend_q) begin
                            state_d     = S_WALK;
                            cnt_d       = ext_q;
                            walk_pend_d = 1'b0;
                        end else begin
                            state_d    = S_SG;
                            cnt_d      = base_q;
                            ext_used_d = 1'b0;
                        end
                    end
                    S_WALK: begin
                        state_d    = S_SG;
                        cnt_d      = base_q;
                        ext_used_d = 1'b0;
                    end
                    S_SG: begin
                        // A waiting side-street car earns exactly one extension per SG visit.
                        if (Sensor_Sync && !ext_used_q) begin
                            cnt_d      = ext_q;
                            ext_used_d = 1'b1;
                        end else begin
                            state_d = S_SY;
                            cnt_d   = yel_q;
                        end
                    end
                    default: begin
                        state_d = S_MG1;
                        cnt_d   = base_q;
                    end
                endcase
            end else if (cnt_q != 4'd0) begin
                cnt_d = cnt_q - 4'd1;
            end
        end

        // A new request outranks any clear on the same clock.
        if (Walk_request_Sync) walk_pend_d = 1'b1;

        lamps_d = lamp_decode(state_d);
    end

    always_ff @(posedge clk or posedge Reset) begin
        if (Reset) begin
            state_q     <= S_MG1;
            cnt_q       <= DEF_BASE;
            base_q      <= DEF_BASE;
            ext_q       <= DEF_EXT;
            yel_q       <= DEF_YEL;
            walk_pend_q <= 1'b0;
            ext_used_q  <= 1'b0;
            lamps_q     <= {L_GRN, L_RED, 1'b0};
        end else begin
            // NOTE: non-blocking so every flop samples pre-edge values.
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            base_q      <= base_d;
            ext_q       <= ext_d;
            yel_q       <= yel_d;
            walk_pend_q <= walk_pend_d;
            ext_used_q  <= ext_used_d;
            lamps_q     <= lamps_d;
        end
    end

    assign main_lamp = lamps_q[6:4];
    assign side_lamp = lamps_q[3:1];
    assign walk_lamp = lamps_q[0];
    assign state_out = state_q;

endmodule
